// File: rtl/rename_map_if.sv
// Decode, free-list, dispatch, commit and flush signals of the rename stage.
// The master modport is the surrounding pipeline and the slave modport is rename_map.
interface rename_map_if #(
   parameter int unsigned ARCH_REGS = 32,
   parameter int unsigned PHYS_REGS = 128
);
   localparam int unsigned AW = $clog2(ARCH_REGS);
   localparam int unsigned TW = $clog2(PHYS_REGS);

   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_rs1;
   logic [AW-1:0] in_rs2;
   logic [AW-1:0] in_rd;
   logic          in_rd_we;

   logic [TW-1:0] free_tag;
   logic          free_empty;
   logic          free_rd_en;
   logic          free_w_en;
   logic [TW-1:0] free_w_data;

   logic          out_valid;
   logic          out_ready;
   logic [TW-1:0] out_prs1;
   logic [TW-1:0] out_prs2;
   logic          out_rs1_mapped;
   logic          out_rs2_mapped;
   logic [TW-1:0] out_prd;
   logic [TW-1:0] out_old_prd;
   logic          out_old_mapped;
   logic          out_rd_alloc;

   logic          commit_valid;
   logic [AW-1:0] commit_rd;
   logic [TW-1:0] commit_prd;
   logic          flush;

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
      output free_tag, free_empty, out_ready,
      output commit_valid, commit_rd, commit_prd, flush,
      input  in_ready, free_rd_en, free_w_en, free_w_data,
      input  out_valid, out_prs1, out_prs2, out_rs1_mapped, out_rs2_mapped,
      input  out_prd, out_old_prd, out_old_mapped, out_rd_alloc
   );

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
      input  free_tag, free_empty, out_ready,
      input  commit_valid, commit_rd, commit_prd, flush,
      output in_ready, free_rd_en, free_w_en, free_w_data,
      output out_valid, out_prs1, out_prs2, out_rs1_mapped, out_rs2_mapped,
      output out_prd, out_old_prd, out_old_mapped, out_rd_alloc
   );
endinterface

// File: rtl/rename_map.sv
// Single-issue register rename: speculative and committed RATs, a free-list pop per
// allocating instruction, tag reclaim at commit and RAT recovery on flush.
module rename_map #(
   parameter int unsigned ARCH_REGS = 32,
   parameter int unsigned PHYS_REGS = 128
) (
   input  logic          clk,
   input  logic          rst,
   rename_map_if.slave   bus
);
   localparam int unsigned AW = $clog2(ARCH_REGS);
   localparam int unsigned TW = $clog2(PHYS_REGS);

   typedef struct packed {
      logic          mapped;
      logic [TW-1:0] tag;
   } rat_entry_t;

   typedef struct packed {
      rat_entry_t    rs1;
      rat_entry_t    rs2;
      rat_entry_t    old;
      logic [TW-1:0] prd;
      logic          alloc;
   } rename_out_t;

   rat_entry_t  spec_rat [ARCH_REGS];
   rat_entry_t  cmt_rat  [ARCH_REGS];
   rename_out_t out_q;
   logic        out_valid_q;

   logic       needs_alloc;
   logic       in_ready_c;
   logic       accept;
   logic       commit_en;
   rat_entry_t cmt_old;
   rat_entry_t alloc_entry;
   rat_entry_t commit_entry;

   // Handshake, pop and reclaim decode; everything here is held inactive during reset.
   assign needs_alloc  = bus.in_rd_we & (bus.in_rd != '0);
   assign in_ready_c   = rst & (!out_valid_q | bus.out_ready) & !bus.flush
                       & (!needs_alloc | !bus.free_empty);
   assign accept       = bus.in_valid & in_ready_c;
   assign commit_en    = bus.commit_valid & (bus.commit_rd != '0);
   assign cmt_old      = cmt_rat[bus.commit_rd];
   assign alloc_entry  = '{mapped: 1'b1, tag: bus.free_tag};
   assign commit_entry = '{mapped: 1'b1, tag: bus.commit_prd};

   assign bus.in_ready    = in_ready_c;
   assign bus.free_rd_en  = accept & needs_alloc;
   assign bus.free_w_en   = commit_en & cmt_old.mapped;
   assign bus.free_w_data = (commit_en & cmt_old.mapped) ? cmt_old.tag : '0;

   // RAT state: commit writes the committed table, flush copies it (with that commit) back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < ARCH_REGS; i++) begin
            spec_rat[AW'(i)] <= '0;
            cmt_rat[AW'(i)]  <= '0;
         end
      end else begin
         if (commit_en) cmt_rat[bus.commit_rd] <= commit_entry;
         if (bus.flush) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) spec_rat[AW'(i)] <= cmt_rat[AW'(i)];
            if (commit_en) spec_rat[bus.commit_rd] <= commit_entry;
         end else if (accept && needs_alloc) begin
            spec_rat[bus.in_rd] <= alloc_entry;
         end
      end
   end

   // Output register: lookups read the RAT before this edge's update, so no bypass.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_q.rs1   <= spec_rat[bus.in_rs1];
         out_q.rs2   <= spec_rat[bus.in_rs2];
         out_q.old   <= spec_rat[bus.in_rd];
         out_q.prd   <= needs_alloc ? bus.free_tag : '0;
         out_q.alloc <= needs_alloc;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid      = out_valid_q;
   assign bus.out_prs1       = out_q.rs1.tag;
   assign bus.out_rs1_mapped = out_q.rs1.mapped;
   assign bus.out_prs2       = out_q.rs2.tag;
   assign bus.out_rs2_mapped = out_q.rs2.mapped;
   assign bus.out_prd        = out_q.prd;
   assign bus.out_old_prd    = out_q.old.tag;
   assign bus.out_old_mapped = out_q.old.mapped;
   assign bus.out_rd_alloc   = out_q.alloc;
endmodule

// File: doc/rename_map.md
# rename_map

Single-issue register rename stage for the out-of-order core. It sits between decode and dispatch and pops one physical tag per destination-writing instruction from the free-list FIFO. It keeps a speculative and a committed register alias table (RAT), and at commit returns each superseded physical tag to the free list.

## Interface
- ARCH_REGS, 32, number of architectural registers; AW = $clog2(ARCH_REGS).
- PHYS_REGS, 128, number of physical registers; TW = $clog2(PHYS_REGS), equal to the free-list data width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid / in_ready  in / out  1  decode handshake.
- in_rs1, in_rs2, in_rd  in  AW  architectural register numbers.
- in_rd_we  in  1  instruction writes rd.
- free_tag  in  TW  head of the free list (combinational read).
- free_empty  in  1  free list empty.
- free_rd_en  out  1  pops the free-list head this cycle.
- free_w_en / free_w_data  out  1 / TW  pushes a reclaimed tag to the free list.
- out_valid / out_ready  out / in  1  dispatch handshake.
- out_prs1, out_prs2  out  TW  source physical tags.
- out_rs1_mapped, out_rs2_mapped  out  1  0 means the source has never been renamed and reads its architectural reset value.
- out_prd  out  TW  destination tag.
- out_old_prd  out  TW  previous speculative mapping of rd.
- out_old_mapped  out  1  out_old_prd is meaningful.
- out_rd_alloc  out  1  a tag was allocated.
- commit_valid, commit_rd, commit_prd  in  1, AW, TW  retire one destination mapping.
- flush  in  1  misprediction recovery: restore the speculative RAT from the committed RAT.

## Operation
- **RAT storage.** Each RAT has ARCH_REGS entries of {mapped, tag}.
- **Reset.** While rst is low, all mapped bits are 0, all tags are 0, and out_valid = 0. All out_* data outputs are 0. free_rd_en = 0 and free_w_en = 0.
- **Allocation need.** needs_alloc = in_rd_we & (in_rd != 0). x0 is never renamed.
- **in_ready** = (!out_valid | out_ready) & !flush & (!needs_alloc | !free_empty).
- **Accept** = in_valid & in_ready.
- **On accept:**
  - The output register loads the speculative RAT lookups for rs1 and rs2 (tag and mapped bit).
  - out_old_prd and out_old_mapped load the current RAT entry for rd.
  - out_prd loads free_tag when needs_alloc, otherwise 0.
  - out_rd_alloc loads needs_alloc.
- **Speculative RAT update.** If needs_alloc, the speculative RAT[rd] is written to {1, free_tag} on the same edge.
- **free_rd_en** = accept & needs_alloc. It is combinational and is never asserted while free_empty.
- **Same-register sources.** Source lookups read the RAT before the update. For example, "add x5, x5, x1" gets the old x5 tag as prs1.
- **Back-to-back dependency.** Instruction N+1 is accepted at least one edge later, so it always sees N's RAT write. No bypass is needed.
- **Output hold.** If out_valid = 1 and out_ready = 0, all out_* signals hold stable.
- **Commit.** When commit_valid & (commit_rd != 0):
  - If committed RAT[commit_rd].mapped = 1: free_w_en = 1 and free_w_data = committed RAT[commit_rd].tag, combinationally in the same cycle.
  - Committed RAT[commit_rd] becomes {1, commit_prd} at the edge.
  - commit_rd = 0 is ignored.
- **Flush.**
  - At the edge, the speculative RAT is overwritten with the committed RAT, including any commit applied in the same cycle (commit first, then copy).
  - out_valid is cleared.
  - No accept occurs in a flush cycle.
  - Tags allocated by squashed instructions are returned by the ROB squash walk, not by this block.

## Timing
- Rename latency is 1 cycle: accept at edge N gives out_valid = 1 after edge N.
- Throughput is 1 instruction per cycle while out_ready = 1 and free tags are available.
- free_empty with needs_alloc stalls: in_ready = 0 and there is no pop. Non-allocating instructions proceed regardless of free_empty.
- Commit and rename in the same cycle act on separate tables and do not interact.
- Commit and flush in the same cycle: the freed tag is pushed, and the flushed speculative RAT includes the new commit mapping.
- Asynchronous reset mid-operation discards all state immediately. Outputs return to their reset values without waiting for clk.

## Test plan
- **Reset then two renames.**
  - Stimulus: release reset; free list supplies tags 0 then 1. Rename rd = 5, rs1 = 5; then rd = 6, rs1 = 5.
  - Required: first output prs1_mapped = 0, prd = 0, old_mapped = 0. Second output prs1 = 0, prs1_mapped = 1, prd = 1.
- **x0 and no-write instructions.**
  - Stimulus: rd = 0 with in_rd_we = 1; then rd = 3 with in_rd_we = 0.
  - Required: free_rd_en = 0 both times; out_rd_alloc = 0 and out_prd = 0.
- **Free list empty.**
  - Stimulus: free_empty = 1 with an allocating instruction → in_ready = 0, no pop, output holds.
  - Stimulus: then a non-allocating instruction → it is accepted.
- **Backpressure.**
  - Stimulus: out_ready = 0 for 3 cycles while in_valid = 1.
  - Required: in_ready = 0 throughout, out_* stable, exactly one pop total.
- **Commit reclaim.**
  - Stimulus: commit x5 → tag 0, then commit x5 → tag 9.
  - Required: first commit gives free_w_en = 0. Second commit gives free_w_en = 1 with free_w_data = 0.
- **Flush with simultaneous commit.**
  - Stimulus: speculative RAT x5 = 9 and committed RAT x5 = 0. Assert flush together with commit x6 → tag 4.
  - Required: after the edge, renaming rs1 = 5 gives prs1 = 0, and rs2 = 6 gives prs2 = 4 with mapped = 1. out_valid is cleared.
